// File: rtl/exc_unit_if.sv
// exc_unit_if: MEM-stage exception request, mtc0/mfc0 access and the
// flush/redirect handshake between the pipeline and exc_unit.
interface exc_unit_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_in_delay;
    logic [7:0]  m_exc;
    logic [31:0] m_badaddr;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic [4:0]  exc_code;

    modport master (
        output m_valid, m_pc, m_in_delay, m_exc, m_badaddr,
        output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ack,
        input  cp0_rdata, flush, redirect_pc, exc_code
    );

    modport slave (
        input  m_valid, m_pc, m_in_delay, m_exc, m_badaddr,
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, redirect_ack,
        output cp0_rdata, flush, redirect_pc, exc_code
    );
endinterface

// File: rtl/exc_unit.sv
// exc_unit: MEM-stage exception/interrupt controller with CP0 Status,
// Cause, EPC and BadVAddr, plus a held flush/redirect handshake to fetch.
// Optional Count/Compare timer is built when EXC_TIMER_EN is defined.
module exc_unit #(
    parameter int unsigned HW_INT_W    = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VEC     = 32'hBFC0_0380
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [HW_INT_W-1:0] hw_int,
    exc_unit_if.slave           bus
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state_q, state_d;

    logic [HW_INT_W-1:0] sync_q [SYNC_STAGES];

    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] redirect_q;
    logic        ti;

    logic [7:0]  ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic        int_pending;
    logic        taken;
    logic        is_eret;
    logic [4:0]  code;
    logic        load_bad;
    logic [31:0] bad_val;
    logic        we_eff;

    // Shift the asynchronous interrupt lines through the synchroniser chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef EXC_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tog_q;
    logic        ti_q;

    // Count advances on every second edge; TI latches on Count==Compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            tog_q     <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            tog_q <= ~tog_q;
            if (tog_q) count_q <= count_q + 32'd1;
            if (count_q == compare_q) ti_q <= 1'b1;
            if (we_eff && bus.cp0_waddr == 5'd9) begin
                count_q <= bus.cp0_wdata;
                tog_q   <= 1'b0;
            end
            if (we_eff && bus.cp0_waddr == 5'd11) begin
                compare_q <= bus.cp0_wdata;
                ti_q      <= 1'b0;
            end
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    // Assemble the architectural views of Cause.IP, Status and Cause.
    always_comb begin
        ip = '0;
        ip[1:0] = ip_sw_q;
        ip[HW_INT_W+1:2] = sync_q[SYNC_STAGES-1];
        ip[7] = ip[7] | ti;
        status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        cause_rd  = {bd_q, ti, 14'b0, ip, 1'b0, code_q, 2'b0};
        int_pending = (|(ip & im_q)) & ie_q & ~exl_q;
    end

    // Prioritise interrupt and exception flags for the MEM-stage instruction.
    always_comb begin
        taken    = (state_q == IDLE) && bus.m_valid && (int_pending || (|bus.m_exc));
        is_eret  = 1'b0;
        code     = 5'h00;
        load_bad = 1'b0;
        bad_val  = bus.m_badaddr;
        if (int_pending) begin
            code = 5'h00;
        end else if (bus.m_exc[7]) begin
            code     = 5'h04;
            load_bad = 1'b1;
            bad_val  = bus.m_pc;
        end else if (bus.m_exc[6]) begin
            code = 5'h0a;
        end else if (bus.m_exc[5]) begin
            code = 5'h08;
        end else if (bus.m_exc[4]) begin
            code = 5'h09;
        end else if (bus.m_exc[3]) begin
            code = 5'h0c;
        end else if (bus.m_exc[2]) begin
            code     = 5'h04;
            load_bad = 1'b1;
        end else if (bus.m_exc[1]) begin
            code     = 5'h05;
            load_bad = 1'b1;
        end else begin
            is_eret = 1'b1;
        end
        we_eff = bus.cp0_we && !taken;
    end

    // Update CP0 registers on a taken event, otherwise apply mtc0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            code_q     <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            redirect_q <= '0;
        end else if (taken) begin
            if (is_eret) begin
                exl_q      <= 1'b0;
                redirect_q <= epc_q;
            end else begin
                code_q     <= code;
                exl_q      <= 1'b1;
                redirect_q <= EXC_VEC;
                if (!exl_q) begin
                    epc_q <= bus.m_in_delay ? bus.m_pc - 32'd4 : bus.m_pc;
                    bd_q  <= bus.m_in_delay;
                end
                if (load_bad) badvaddr_q <= bad_val;
            end
        end else if (we_eff) begin
            case (bus.cp0_waddr)
                5'd12: begin
                    im_q  <= bus.cp0_wdata[15:8];
                    exl_q <= bus.cp0_wdata[1];
                    ie_q  <= bus.cp0_wdata[0];
                end
                5'd13:   ip_sw_q <= bus.cp0_wdata[9:8];
                5'd14:   epc_q   <= bus.cp0_wdata;
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: enter FLUSH on a taken event, leave on redirect_ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (taken) state_d = FLUSH;
            FLUSH:   if (bus.redirect_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and CP0 registers.
    always_comb begin
        bus.flush       = (state_q == FLUSH);
        bus.redirect_pc = redirect_q;
        bus.exc_code    = code_q;
    end

    // mfc0 read mux; unmapped addresses read zero.
    always_comb begin
        case (bus.cp0_raddr)
            5'd8:    bus.cp0_rdata = badvaddr_q;
            5'd9:    bus.cp0_rdata = count_rd;
            5'd11:   bus.cp0_rdata = compare_rd;
            5'd12:   bus.cp0_rdata = status_rd;
            5'd13:   bus.cp0_rdata = cause_rd;
            5'd14:   bus.cp0_rdata = epc_q;
            default: bus.cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_unit.sv
// tb_exc_unit: directed vectors for exc_unit in its default build.
module tb_exc_unit;
    logic       clk;
    logic       resetn;
    logic [5:0] hw_int;
    int         vec;
    int         miss;

    exc_unit_if bus ();

    exc_unit #(
        .HW_INT_W    (6),
        .SYNC_STAGES (2),
        .EXC_VEC     (32'hBFC0_0380)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .hw_int (hw_int),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.cp0_raddr = addr;
        #1;
        chk(tag, bus.cp0_rdata, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m_valid    = 1'b0;
        bus.m_pc       = '0;
        bus.m_in_delay = 1'b0;
        bus.m_exc      = '0;
        bus.m_badaddr  = '0;
        bus.cp0_we     = 1'b0;
        bus.cp0_waddr  = '0;
        bus.cp0_wdata  = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        clk1();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic ack_release(input string tag);
        idle();
        bus.redirect_ack = 1'b1;
        clk1();
        chk(tag, {31'b0, bus.flush}, 32'd0);
        bus.redirect_ack = 1'b0;
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        resetn = 1'b0;
        hw_int = '0;
        bus.redirect_ack = 1'b0;
        bus.cp0_raddr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", {31'b0, bus.flush}, 32'd0);
        chk("rst_redirect", bus.redirect_pc, 32'd0);
        chk("rst_code", {27'b0, bus.exc_code}, 32'd0);
        chk_reg("rst_status", 5'd12, 32'h0040_0000);
        chk_reg("rst_cause", 5'd13, 32'd0);
        chk_reg("rst_epc", 5'd14, 32'd0);
        resetn = 1'b1;
        clk1();

        // ri, not in delay slot
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h8000_0100;
        bus.m_exc   = 8'h40;
        clk1();
        idle();
        chk("ri_flush", {31'b0, bus.flush}, 32'd1);
        chk("ri_redirect", bus.redirect_pc, 32'hBFC0_0380);
        chk("ri_code", {27'b0, bus.exc_code}, 32'h0a);
        chk_reg("ri_epc", 5'd14, 32'h8000_0100);
        chk_reg("ri_status", 5'd12, 32'h0040_0002);
        clk1();
        chk("ri_hold2", {31'b0, bus.flush}, 32'd1);
        clk1();
        chk("ri_hold3", {31'b0, bus.flush}, 32'd1);
        ack_release("ri_release");

        mtc0(5'd12, 32'd0);
        chk_reg("status_clr", 5'd12, 32'h0040_0000);

        // ades in delay slot
        bus.m_valid    = 1'b1;
        bus.m_pc       = 32'h8000_0204;
        bus.m_in_delay = 1'b1;
        bus.m_exc      = 8'h02;
        bus.m_badaddr  = 32'h0000_0003;
        clk1();
        idle();
        chk_reg("ades_epc", 5'd14, 32'h8000_0200);
        chk_reg("ades_cause", 5'd13, 32'h8000_0014);
        chk_reg("ades_badv", 5'd8, 32'h0000_0003);
        chk("ades_code", {27'b0, bus.exc_code}, 32'h05);
        ack_release("ades_release");

        // interrupt beats ov after two-stage sync
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        clk1();
        clk1();
        chk_reg("int_ip", 5'd13, 32'h8000_0414);
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h8000_0300;
        bus.m_exc   = 8'h08;
        clk1();
        idle();
        hw_int = '0;
        chk("int_code", {27'b0, bus.exc_code}, 32'h00);
        chk("int_flush", {31'b0, bus.flush}, 32'd1);
        chk_reg("int_epc", 5'd14, 32'h8000_0300);
        chk_reg("int_status", 5'd12, 32'h0040_0403);
        ack_release("int_release");

        // second exception while EXL=1 leaves EPC alone
        bus.m_valid = 1'b1;
        bus.m_pc    = 32'h8000_0400;
        bus.m_exc   = 8'h20;
        clk1();
        idle();
        chk("sys_code", {27'b0, bus.exc_code}, 32'h08);
        chk_reg("sys_epc_kept", 5'd14, 32'h8000_0300);
        ack_release("sys_release");

        // eret with a dropped same-cycle mtc0 to EPC
        mtc0(5'd14, 32'h8000_1000);
        chk_reg("epc_write", 5'd14, 32'h8000_1000);
        bus.m_valid   = 1'b1;
        bus.m_exc     = 8'h01;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h0000_1234;
        clk1();
        idle();
        chk("eret_redirect", bus.redirect_pc, 32'h8000_1000);
        chk("eret_flush", {31'b0, bus.flush}, 32'd1);
        chk("eret_code", {27'b0, bus.exc_code}, 32'h08);
        chk_reg("eret_status", 5'd12, 32'h0040_0401);
        chk_reg("eret_epc", 5'd14, 32'h8000_1000);
        chk_reg("unmapped9", 5'd9, 32'd0);
        chk_reg("unmapped3", 5'd3, 32'd0);

        // asynchronous reset during FLUSH
        resetn = 1'b0;
        #1;
        chk("areset_flush", {31'b0, bus.flush}, 32'd0);
        chk_reg("areset_status", 5'd12, 32'h0040_0000);
        chk("areset_redirect", bus.redirect_pc, 32'd0);
        resetn = 1'b1;
        clk1();
        chk("post_reset_flush", {31'b0, bus.flush}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
